complexnumber_sequencer: RTL and testbench
==========================================

Name: complexnumber_sequencer

Overview:
Command-driven controller that sequences the complex-number datapath (dual-port operand memory, operand register stage, complex ALU). It accepts LOAD and COMPUTE commands over a valid/ready handshake and drives memory addresses, write enable and ALU select. It waits out the fixed pipeline latency, captures the 22-bit result and both overflow flags, and returns one response per command over a second valid/ready handshake. It also keeps a saturating overflow event counter for software.

Parameters:
ADDR_W, 5, operand memory address width per port
DATA_W, 10, signed operand width per port
RES_W, 22, ALU result width
PIPE_LAT, 2, cycles from address issue to a valid ALU result (memory read plus operand register); legal range 1..7
OVF_CNT_W, 8, width of the saturating overflow counter

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  controller can accept a command
cmd_kind  in  1  0=LOAD, 1=COMPUTE
cmd_select  in  2  ALU operation code, passed through unmodified
cmd_addr_a  in  ADDR_W  port-A address
cmd_addr_b  in  ADDR_W  port-B address
cmd_data_a  in  DATA_W  LOAD data for port A
cmd_data_b  in  DATA_W  LOAD data for port B
dp_write  out  1  datapath memory write enable
dp_select  out  2  datapath ALU select
dp_address_A  out  ADDR_W  datapath port-A address
dp_address_B  out  ADDR_W  datapath port-B address
dp_op_A  out  DATA_W  datapath port-A write data
dp_op_B  out  DATA_W  datapath port-B write data
dp_result  in  RES_W  datapath ALU result
dp_overflow_real  in  1  datapath real overflow
dp_overflow_imaginary  in  1  datapath imaginary overflow
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts response
rsp_result  out  RES_W  captured result (0 for LOAD)
rsp_ovf_real  out  1  captured real overflow
rsp_ovf_imag  out  1  captured imaginary overflow
rsp_err  out  1  command rejected
busy  out  1  state is not IDLE
ovf_count  out  OVF_CNT_W  saturating count of COMPUTE responses with any overflow

Behaviour:
- Reset (asynchronous, reset=0): state=IDLE; dp_write=0 immediately; dp_select, dp_address_*, dp_op_*, rsp_* and ovf_count = 0; cmd_ready=0 while reset is asserted, 1 on the first cycle after release.
- States: IDLE, WRITE, ISSUE, CAPTURE, RESP.
- IDLE: cmd_ready=1. On cmd_valid&cmd_ready, latch all cmd_* fields. Transition: LOAD -> WRITE, COMPUTE -> ISSUE.
- WRITE (exactly 1 cycle): dp_write=1 with latched addresses and data. If cmd_addr_a==cmd_addr_b, dp_write stays 0 and rsp_err=1 (no write is performed). Transition -> RESP with rsp_result=0 and overflow flags=0.
- ISSUE: dp_write=0; latched addresses and select are driven and held stable until CAPTURE completes. A down-counter is loaded with PIPE_LAT-1 on entry and decrements each cycle; at 0 the state moves to CAPTURE.
- CAPTURE (1 cycle): sample dp_result and both overflow flags into the response registers; rsp_err=0. Increment ovf_count if either flag is set, saturating at all-ones. Transition -> RESP.
- COMPUTE latency: PIPE_LAT+1 cycles from the accept edge to rsp_valid=1. Equal addresses are legal for COMPUTE.
- RESP: rsp_valid=1 and the response fields are held stable until rsp_ready=1. On handshake -> IDLE, rsp_valid=0 next cycle. cmd_ready=0 throughout, so there is no overlap and at most one command is in flight.
- dp_address_*/dp_select keep their last values in IDLE; dp_write is 1 only in WRITE.
- Reset mid-operation: the in-flight command and any pending response are discarded; no write is issued after reset asserts.
- cmd_* fields change while cmd_valid=1 & cmd_ready=0: ignored; the fields are sampled only at accept.

Decomposition:
- Package cnc_pkg: state enum, cmd_kind constants (CMD_LOAD=0, CMD_COMPUTE=1), default widths ADDR_W/DATA_W/RES_W.
- One natural sub-module: cnc_rsp_reg, holding the response register, valid/ready hold logic and the saturating ovf_count.

Test Plan:
- Reset mid-ISSUE, 1 cycle after a COMPUTE accept -> dp_write=0, rsp_valid=0, busy=0 asynchronously; cmd_ready=1 the cycle after release; no response ever appears.
- LOAD addr_a=3, addr_b=4, data_a=10'sd100, data_b=-10'sd50 -> dp_write=1 for exactly one cycle with those values; response rsp_result=0, rsp_err=0.
- LOAD addr_a=addr_b=7 -> dp_write never asserted; response rsp_err=1.
- COMPUTE select=2'b10, addr 3/4, PIPE_LAT=2, datapath model drives dp_result=22'sd1234 -> rsp_valid rises exactly 3 cycles after accept with rsp_result=1234; addresses stay stable across ISSUE and CAPTURE.
- COMPUTE response with rsp_ready held low 5 cycles -> rsp fields stable, cmd_ready=0 throughout; second cmd_valid is accepted only after the handshake.
- 300 COMPUTEs with dp_overflow_real=1 -> ovf_count saturates at 255; responses with no overflow leave it unchanged.

Source files
------------

// File: rtl/cnc_pkg.sv
// Shared types and default widths for the complex-number datapath sequencer.
package cnc_pkg;

  // Default widths; the top-level parameters take these as their defaults.
  localparam int DEF_ADDR_W    = 5;
  localparam int DEF_DATA_W    = 10;
  localparam int DEF_RES_W     = 22;
  localparam int DEF_PIPE_LAT  = 2;
  localparam int DEF_OVF_CNT_W = 8;

  // Latency down-counter width; PIPE_LAT is limited to 1..7, so PIPE_LAT-1 fits in 3 bits.
  localparam int CNT_W = 3;

  // Command kinds carried on cmd_kind.
  localparam logic CMD_LOAD    = 1'b0;
  localparam logic CMD_COMPUTE = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WRITE   = 3'd1,
    ST_ISSUE   = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_RESP    = 3'd4
  } state_e;

endpackage

// File: rtl/cnc_rsp_reg.sv
// Response register with valid/ready hold and a saturating overflow event counter.
module cnc_rsp_reg
  import cnc_pkg::*;
#(
  parameter int RES_W     = DEF_RES_W,
  parameter int OVF_CNT_W = DEF_OVF_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load_i,        // finishing a LOAD: zero result, error from caller
  input  logic                 load_err_i,
  input  logic                 capture_i,     // finishing a COMPUTE: sample the datapath
  input  logic [RES_W-1:0]     result_i,
  input  logic                 ovf_real_i,
  input  logic                 ovf_imag_i,
  input  logic                 rsp_ready_i,
  output logic                 rsp_valid_o,
  output logic [RES_W-1:0]     rsp_result_o,
  output logic                 rsp_ovf_real_o,
  output logic                 rsp_ovf_imag_o,
  output logic                 rsp_err_o,
  output logic [OVF_CNT_W-1:0] ovf_count_o
);

  logic                 valid_q, valid_d;
  logic [RES_W-1:0]     result_q, result_d;
  logic                 ovf_real_q, ovf_real_d;
  logic                 ovf_imag_q, ovf_imag_d;
  logic                 err_q, err_d;
  logic [OVF_CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;

  // Next response contents: load on LOAD/COMPUTE completion, drop valid on handshake.
  always_comb begin
    valid_d    = valid_q;
    result_d   = result_q;
    ovf_real_d = ovf_real_q;
    ovf_imag_d = ovf_imag_q;
    err_d      = err_q;
    ovf_cnt_d  = ovf_cnt_q;
    if (load_i) begin
      valid_d    = 1'b1;
      result_d   = '0;
      ovf_real_d = 1'b0;
      ovf_imag_d = 1'b0;
      err_d      = load_err_i;
    end else if (capture_i) begin
      valid_d    = 1'b1;
      result_d   = result_i;
      ovf_real_d = ovf_real_i;
      ovf_imag_d = ovf_imag_i;
      err_d      = 1'b0;
      if ((ovf_real_i || ovf_imag_i) && (ovf_cnt_q != '1)) begin
        ovf_cnt_d = ovf_cnt_q + OVF_CNT_W'(1);
      end
    end else if (valid_q && rsp_ready_i) begin
      valid_d = 1'b0;
    end
  end

  // Response and counter registers; a reset discards any pending response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      result_q   <= '0;
      ovf_real_q <= 1'b0;
      ovf_imag_q <= 1'b0;
      err_q      <= 1'b0;
      ovf_cnt_q  <= '0;
    end else begin
      valid_q    <= valid_d;
      result_q   <= result_d;
      ovf_real_q <= ovf_real_d;
      ovf_imag_q <= ovf_imag_d;
      err_q      <= err_d;
      ovf_cnt_q  <= ovf_cnt_d;
    end
  end

  assign rsp_valid_o    = valid_q;
  assign rsp_result_o   = result_q;
  assign rsp_ovf_real_o = ovf_real_q;
  assign rsp_ovf_imag_o = ovf_imag_q;
  assign rsp_err_o      = err_q;
  assign ovf_count_o    = ovf_cnt_q;

endmodule

// File: rtl/complexnumber_sequencer.sv
// Command sequencer for the complex-number datapath: LOAD writes both operand
// memory ports, COMPUTE reads them, waits the pipeline latency and returns the ALU result.
module complexnumber_sequencer
  import cnc_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int RES_W     = DEF_RES_W,
  parameter int PIPE_LAT  = DEF_PIPE_LAT,
  parameter int OVF_CNT_W = DEF_OVF_CNT_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_kind,
  input  logic [1:0]           cmd_select,
  input  logic [ADDR_W-1:0]    cmd_addr_a,
  input  logic [ADDR_W-1:0]    cmd_addr_b,
  input  logic [DATA_W-1:0]    cmd_data_a,
  input  logic [DATA_W-1:0]    cmd_data_b,
  output logic                 dp_write,
  output logic [1:0]           dp_select,
  output logic [ADDR_W-1:0]    dp_address_A,
  output logic [ADDR_W-1:0]    dp_address_B,
  output logic [DATA_W-1:0]    dp_op_A,
  output logic [DATA_W-1:0]    dp_op_B,
  input  logic [RES_W-1:0]     dp_result,
  input  logic                 dp_overflow_real,
  input  logic                 dp_overflow_imaginary,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [RES_W-1:0]     rsp_result,
  output logic                 rsp_ovf_real,
  output logic                 rsp_ovf_imag,
  output logic                 rsp_err,
  output logic                 busy,
  output logic [OVF_CNT_W-1:0] ovf_count
);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    lat_cnt_q, lat_cnt_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic                dp_write_q, dp_write_d;
  logic [1:0]          sel_q, sel_d;
  logic [ADDR_W-1:0]   addr_a_q, addr_a_d;
  logic [ADDR_W-1:0]   addr_b_q, addr_b_d;
  logic [DATA_W-1:0]   op_a_q, op_a_d;
  logic [DATA_W-1:0]   op_b_q, op_b_d;

  logic in_write, in_capture, write_err;

  assign in_write   = (state_q == ST_WRITE);
  assign in_capture = (state_q == ST_CAPTURE);
  // A LOAD to the same address on both ports is rejected and never written.
  assign write_err  = (addr_a_q == addr_b_q);

  // Next-state and datapath drive; command fields are captured only at accept.
  // NOTE: every signal gets a default before the case so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    lat_cnt_d  = lat_cnt_q;
    dp_write_d = 1'b0;
    sel_d      = sel_q;
    addr_a_d   = addr_a_q;
    addr_b_d   = addr_b_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          sel_d    = cmd_select;
          addr_a_d = cmd_addr_a;
          addr_b_d = cmd_addr_b;
          op_a_d   = cmd_data_a;
          op_b_d   = cmd_data_b;
          if (cmd_kind == CMD_LOAD) begin
            state_d    = ST_WRITE;
            dp_write_d = (cmd_addr_a != cmd_addr_b);
          end else begin
            state_d   = ST_ISSUE;
            lat_cnt_d = CNT_W'(PIPE_LAT - 1);
          end
        end
      end
      ST_WRITE:   state_d = ST_RESP;
      ST_ISSUE: begin
        if (lat_cnt_q == '0) begin
          state_d = ST_CAPTURE;
        end else begin
          lat_cnt_d = lat_cnt_q - CNT_W'(1);
        end
      end
      ST_CAPTURE: state_d = ST_RESP;
      ST_RESP: begin
        if (rsp_valid && rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default:    state_d = ST_IDLE;
    endcase
    cmd_ready_d = (state_d == ST_IDLE);
  end

  // State, latency counter and registered datapath drive.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      lat_cnt_q   <= '0;
      cmd_ready_q <= 1'b0;
      dp_write_q  <= 1'b0;
      sel_q       <= '0;
      addr_a_q    <= '0;
      addr_b_q    <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
    end else begin
      state_q     <= state_d;
      lat_cnt_q   <= lat_cnt_d;
      cmd_ready_q <= cmd_ready_d;
      dp_write_q  <= dp_write_d;
      sel_q       <= sel_d;
      addr_a_q    <= addr_a_d;
      addr_b_q    <= addr_b_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
    end
  end

  cnc_rsp_reg #(
    .RES_W     (RES_W),
    .OVF_CNT_W (OVF_CNT_W)
  ) u_rsp_reg (
    .clk            (clk),
    .rst_n          (reset),
    .load_i         (in_write),
    .load_err_i     (write_err),
    .capture_i      (in_capture),
    .result_i       (dp_result),
    .ovf_real_i     (dp_overflow_real),
    .ovf_imag_i     (dp_overflow_imaginary),
    .rsp_ready_i    (rsp_ready),
    .rsp_valid_o    (rsp_valid),
    .rsp_result_o   (rsp_result),
    .rsp_ovf_real_o (rsp_ovf_real),
    .rsp_ovf_imag_o (rsp_ovf_imag),
    .rsp_err_o      (rsp_err),
    .ovf_count_o    (ovf_count)
  );

  assign cmd_ready    = cmd_ready_q;
  assign dp_write     = dp_write_q;
  assign dp_select    = sel_q;
  assign dp_address_A = addr_a_q;
  assign dp_address_B = addr_b_q;
  assign dp_op_A      = op_a_q;
  assign dp_op_B      = op_b_q;
  assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_complexnumber_sequencer.sv
// Directed bench for complexnumber_sequencer with an expected-response scoreboard.
module tb_complexnumber_sequencer;

  localparam int ADDR_W    = 5;
  localparam int DATA_W    = 10;
  localparam int RES_W     = 22;
  localparam int OVF_CNT_W = 8;

  typedef struct {
    logic [RES_W-1:0] result;
    logic             ovr;
    logic             ovi;
    logic             err;
  } rsp_t;

  logic                 clk = 1'b0;
  logic                 reset = 1'b0;
  logic                 cmd_valid = 1'b0;
  logic                 cmd_ready;
  logic                 cmd_kind = 1'b0;
  logic [1:0]           cmd_select = '0;
  logic [ADDR_W-1:0]    cmd_addr_a = '0;
  logic [ADDR_W-1:0]    cmd_addr_b = '0;
  logic [DATA_W-1:0]    cmd_data_a = '0;
  logic [DATA_W-1:0]    cmd_data_b = '0;
  logic                 dp_write;
  logic [1:0]           dp_select;
  logic [ADDR_W-1:0]    dp_address_A;
  logic [ADDR_W-1:0]    dp_address_B;
  logic [DATA_W-1:0]    dp_op_A;
  logic [DATA_W-1:0]    dp_op_B;
  logic [RES_W-1:0]     dp_result = '0;
  logic                 dp_overflow_real = 1'b0;
  logic                 dp_overflow_imaginary = 1'b0;
  logic                 rsp_valid;
  logic                 rsp_ready = 1'b0;
  logic [RES_W-1:0]     rsp_result;
  logic                 rsp_ovf_real;
  logic                 rsp_ovf_imag;
  logic                 rsp_err;
  logic                 busy;
  logic [OVF_CNT_W-1:0] ovf_count;

  rsp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   wr_cnt = 0;
  int   exp_ovf = 0;

  complexnumber_sequencer dut (
    .clk                   (clk),
    .reset                 (reset),
    .cmd_valid             (cmd_valid),
    .cmd_ready             (cmd_ready),
    .cmd_kind              (cmd_kind),
    .cmd_select            (cmd_select),
    .cmd_addr_a            (cmd_addr_a),
    .cmd_addr_b            (cmd_addr_b),
    .cmd_data_a            (cmd_data_a),
    .cmd_data_b            (cmd_data_b),
    .dp_write              (dp_write),
    .dp_select             (dp_select),
    .dp_address_A          (dp_address_A),
    .dp_address_B          (dp_address_B),
    .dp_op_A               (dp_op_A),
    .dp_op_B               (dp_op_B),
    .dp_result             (dp_result),
    .dp_overflow_real      (dp_overflow_real),
    .dp_overflow_imaginary (dp_overflow_imaginary),
    .rsp_valid             (rsp_valid),
    .rsp_ready             (rsp_ready),
    .rsp_result            (rsp_result),
    .rsp_ovf_real          (rsp_ovf_real),
    .rsp_ovf_imag          (rsp_ovf_imag),
    .rsp_err               (rsp_err),
    .busy                  (busy),
    .ovf_count             (ovf_count)
  );

  always #5 clk = ~clk;

  // Counts clock edges on which a memory write is presented to the datapath.
  always @(posedge clk) if (dp_write) wr_cnt++;

  // Hard time limit so a stuck design cannot hang the run.
  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      $error("comparison %s did not match", tag);
    end
  endtask

  // Present a command and return at posedge+1 of the edge that accepted it.
  task automatic send(input logic kind, input logic [1:0] sel,
                      input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] b,
                      input logic [DATA_W-1:0] da, input logic [DATA_W-1:0] db);
    int t = 0;
    cmd_kind = kind; cmd_select = sel;
    cmd_addr_a = a;  cmd_addr_b = b;
    cmd_data_a = da; cmd_data_b = db;
    cmd_valid = 1'b1;
    while (!cmd_ready && t < 50) begin
      @(posedge clk); #1; t++;
    end
    check("accept_wait", (t < 50), 1'b1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  // Count cycles from accept to rsp_valid, checking the issued operands stay stable.
  task automatic wait_rsp(input logic [1:0] sel, input logic [ADDR_W-1:0] a,
                          input logic [ADDR_W-1:0] b, input int exp_lat);
    int lat = 0;
    while (!rsp_valid && lat < 20) begin
      check("issue_addr_a", dp_address_A, a);
      check("issue_addr_b", dp_address_B, b);
      check("issue_select", dp_select, sel);
      check("issue_no_write", dp_write, 1'b0);
      @(posedge clk); #1; lat++;
    end
    check("compute_latency", lat, exp_lat);
  endtask

  // Hold rsp_ready low for 'hold' cycles, then handshake and compare against the scoreboard.
  task automatic recv(input int hold);
    rsp_t exp;
    logic [RES_W-1:0] s_res;
    logic s_ovr, s_ovi, s_err;
    check("rsp_valid_present", rsp_valid, 1'b1);
    check("sb_not_empty", (sb_q.size() != 0), 1'b1);
    s_res = rsp_result; s_ovr = rsp_ovf_real; s_ovi = rsp_ovf_imag; s_err = rsp_err;
    for (int i = 0; i < hold; i++) begin
      rsp_ready = 1'b0;
      @(posedge clk); #1;
      check("hold_valid", rsp_valid, 1'b1);
      check("hold_result", rsp_result, s_res);
      check("hold_flags", {rsp_ovf_real, rsp_ovf_imag, rsp_err}, {s_ovr, s_ovi, s_err});
      check("hold_cmd_ready", cmd_ready, 1'b0);
    end
    if (sb_q.size() != 0) begin
      exp = sb_q.pop_front();
      check("rsp_result", rsp_result, exp.result);
      check("rsp_ovf_real", rsp_ovf_real, exp.ovr);
      check("rsp_ovf_imag", rsp_ovf_imag, exp.ovi);
      check("rsp_err", rsp_err, exp.err);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check("rsp_valid_drop", rsp_valid, 1'b0);
  endtask

  initial begin
    int wr0;
    int seen;

    // Reset state while reset is held low.
    #2;
    check("rst_dp_write", dp_write, 1'b0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_cmd_ready", cmd_ready, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_ovf_count", ovf_count, 0);
    check("rst_dp_addr", {dp_address_A, dp_address_B, dp_select}, 0);
    check("rst_rsp_fields", {rsp_result, rsp_ovf_real, rsp_ovf_imag, rsp_err}, 0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_cmd_ready_held", cmd_ready, 1'b0);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    check("post_rst_cmd_ready", cmd_ready, 1'b1);

    // LOAD 3/4 with 100 / -50; overflow inputs high to show LOAD ignores them.
    dp_overflow_real = 1'b1; dp_overflow_imaginary = 1'b1; dp_result = 22'h12345;
    wr0 = wr_cnt;
    send(1'b0, 2'b00, 5'd3, 5'd4, 10'd100, 10'h3CE);
    sb_q.push_back('{result: '0, ovr: 1'b0, ovi: 1'b0, err: 1'b0});
    check("load_write", dp_write, 1'b1);
    check("load_addr_a", dp_address_A, 5'd3);
    check("load_addr_b", dp_address_B, 5'd4);
    check("load_op_a", dp_op_A, 10'd100);
    check("load_op_b", dp_op_B, 10'h3CE);
    check("load_busy", busy, 1'b1);
    @(posedge clk); #1;
    check("load_write_one_cycle", dp_write, 1'b0);
    recv(0);
    check("load_write_count", wr_cnt - wr0, 1);
    check("load_idle", busy, 1'b0);

    // LOAD with equal addresses is rejected and never writes.
    wr0 = wr_cnt;
    send(1'b0, 2'b00, 5'd7, 5'd7, 10'd5, 10'd6);
    sb_q.push_back('{result: '0, ovr: 1'b0, ovi: 1'b0, err: 1'b1});
    check("eq_load_no_write", dp_write, 1'b0);
    @(posedge clk); #1;
    recv(0);
    check("eq_load_write_count", wr_cnt - wr0, 0);

    // COMPUTE select=10, addr 3/4, result 1234, no overflow.
    dp_overflow_real = 1'b0; dp_overflow_imaginary = 1'b0; dp_result = 22'd1234;
    send(1'b1, 2'b10, 5'd3, 5'd4, 10'd0, 10'd0);
    sb_q.push_back('{result: 22'd1234, ovr: 1'b0, ovi: 1'b0, err: 1'b0});
    wait_rsp(2'b10, 5'd3, 5'd4, 3);
    check("compute_addr_a_at_rsp", dp_address_A, 5'd3);
    recv(0);
    check("no_ovf_count_kept", ovf_count, exp_ovf);

    // COMPUTE with equal addresses and imaginary overflow.
    dp_overflow_imaginary = 1'b1; dp_result = 22'h3FFFFF;
    send(1'b1, 2'b11, 5'd5, 5'd5, 10'd0, 10'd0);
    sb_q.push_back('{result: 22'h3FFFFF, ovr: 1'b0, ovi: 1'b1, err: 1'b0});
    exp_ovf++;
    wait_rsp(2'b11, 5'd5, 5'd5, 3);
    recv(0);
    check("imag_ovf_count", ovf_count, exp_ovf);
    dp_overflow_imaginary = 1'b0;

    // Back-pressure: response held 5 cycles while a second command waits.
    dp_result = 22'h2AAAA;
    send(1'b1, 2'b01, 5'd1, 5'd2, 10'd0, 10'd0);
    sb_q.push_back('{result: 22'h2AAAA, ovr: 1'b0, ovi: 1'b0, err: 1'b0});
    wait_rsp(2'b01, 5'd1, 5'd2, 3);
    cmd_valid = 1'b1; cmd_kind = 1'b0;
    cmd_addr_a = 5'd20; cmd_addr_b = 5'd21; cmd_data_a = 10'd1; cmd_data_b = 10'd2;
    repeat (2) begin
      @(posedge clk); #1;
      check("bp_cmd_ready", cmd_ready, 1'b0);
      check("bp_rsp_result", rsp_result, 22'h2AAAA);
    end
    cmd_addr_a = 5'd9; cmd_addr_b = 5'd10; cmd_data_a = 10'd77; cmd_data_b = 10'd88;
    recv(3);
    check("bp_ready_after_hs", cmd_ready, 1'b1);
    sb_q.push_back('{result: '0, ovr: 1'b0, ovi: 1'b0, err: 1'b0});
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check("bp_late_write", dp_write, 1'b1);
    check("bp_late_addr_a", dp_address_A, 5'd9);
    check("bp_late_op_b", dp_op_B, 10'd88);
    @(posedge clk); #1;
    recv(0);

    // Reset one cycle into ISSUE: everything clears and no response appears.
    dp_overflow_real = 1'b1;
    send(1'b1, 2'b00, 5'd2, 5'd3, 10'd0, 10'd0);
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    check("midrst_dp_write", dp_write, 1'b0);
    check("midrst_rsp_valid", rsp_valid, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_cmd_ready", cmd_ready, 1'b0);
    check("midrst_ovf_count", ovf_count, 0);
    exp_ovf = 0;
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    check("midrst_ready_after", cmd_ready, 1'b1);
    seen = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (rsp_valid || busy) seen++;
    end
    check("midrst_no_rsp", seen, 0);

    // 300 overflowing COMPUTEs saturate the counter at 255.
    for (int i = 0; i < 300; i++) begin
      dp_overflow_real = 1'b1;
      dp_result = RES_W'(i * 37);
      send(1'b1, 2'(i), 5'(i), 5'(i + 1), 10'd0, 10'd0);
      sb_q.push_back('{result: RES_W'(i * 37), ovr: 1'b1, ovi: 1'b0, err: 1'b0});
      wait_rsp(2'(i), 5'(i), 5'(i + 1), 3);
      recv(0);
      if (exp_ovf < 255) exp_ovf++;
      check("sat_ovf_count", ovf_count, exp_ovf);
    end
    check("sat_final", ovf_count, 8'd255);

    // No overflow after saturation keeps the counter at 255.
    dp_overflow_real = 1'b0; dp_result = 22'd42;
    send(1'b1, 2'b00, 5'd8, 5'd9, 10'd0, 10'd0);
    sb_q.push_back('{result: 22'd42, ovr: 1'b0, ovi: 1'b0, err: 1'b0});
    wait_rsp(2'b00, 5'd8, 5'd9, 3);
    recv(0);
    check("sat_hold", ovf_count, 8'd255);
    check("sb_drained", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
